// File: rtl/cache_control_nway.sv
// N-way set-associative write-back cache controller.
// Owns the per-set replacement state and drives the way-indexed tag, valid, dirty and data
// array write enables of the cache datapath. On a miss, invalid ways are used before the
// replacement policy is consulted.
// Optional feature macro CACHE_CTRL_PLRU_EN: when defined, tree pseudo-LRU replacement is
// used; otherwise a per-set round-robin counter that advances on every fill.
module cache_control_nway #(
  parameter int unsigned WAYS     = 4,
  parameter int unsigned SET_BITS = 3,
  parameter int unsigned WAY_BITS = $clog2(WAYS)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_mem_read,
  input  logic                i_mem_write,
  input  logic [SET_BITS-1:0] i_set_idx,
  input  logic [WAYS-1:0]     i_hit,
  input  logic [WAYS-1:0]     i_valid,
  input  logic [WAYS-1:0]     i_dirty,
  input  logic                i_pmem_resp,
  output logic                o_mem_resp,
  output logic                o_pmem_read,
  output logic                o_pmem_write,
  output logic [WAYS-1:0]     o_data_write,
  output logic [WAYS-1:0]     o_tag_write,
  output logic [WAYS-1:0]     o_valid_write,
  output logic [WAYS-1:0]     o_dirty_write,
  output logic                o_dirty_in,
  output logic                o_datainmux_sel,
  output logic                o_addrmux_sel,
  output logic [WAY_BITS-1:0] o_victim_way
);

  localparam int unsigned NUM_SETS = 2 ** SET_BITS;

  typedef enum logic [1:0] {S_IDLE, S_EVICT, S_FILL} state_t;

  state_t              r_state, w_state_next;
  logic [WAY_BITS-1:0] r_victim_way, w_victim_next;
  logic [SET_BITS-1:0] r_miss_set;
  logic                w_latch_set;
  logic                w_fill_done;
  logic                w_req, w_is_hit;
  logic                w_any_invalid;
  logic [WAY_BITS-1:0] w_first_invalid, w_policy_pick, w_victim;
  logic                w_victim_dirty;
  logic [WAYS-1:0]     w_victim_oh;

  assign w_req          = i_mem_read | i_mem_write;
  assign w_is_hit       = |i_hit;
  assign w_victim       = w_any_invalid ? w_first_invalid : w_policy_pick;
  assign w_victim_dirty = i_valid[w_victim] & i_dirty[w_victim];
  assign w_victim_oh    = {{(WAYS-1){1'b0}}, 1'b1} << r_victim_way;
  assign o_victim_way   = r_victim_way;

  // Lowest-index invalid way of the indexed set.
  always_comb begin
    w_any_invalid   = 1'b0;
    w_first_invalid = '0;
    for (int i = int'(WAYS) - 1; i >= 0; i--) begin
      if (!i_valid[i]) begin
        w_any_invalid   = 1'b1;
        w_first_invalid = WAY_BITS'(i);
      end
    end
  end

`ifdef CACHE_CTRL_PLRU_EN
  logic [WAYS-2:0]     r_plru [NUM_SETS];
  logic [WAYS-2:0]     w_plru_upd;
  logic [WAY_BITS-1:0] w_hit_way, w_touch_way, w_plru_pick;
  logic [SET_BITS-1:0] w_touch_set;
  logic                w_touch_en;

  // Encode the one-hot hit vector into a way index.
  always_comb begin
    w_hit_way = '0;
    for (int i = 0; i < int'(WAYS); i++) begin
      if (i_hit[i]) w_hit_way = WAY_BITS'(i);
    end
  end

  // Walk the heap-ordered tree from the root; a 0 node bit steps to the lower half.
  always_comb begin
    int unsigned node;
    node = 1;
    for (int l = 0; l < int'(WAY_BITS); l++) begin
      node = 2 * node + 32'(r_plru[i_set_idx][node-1]);
    end
    w_plru_pick = WAY_BITS'(node - WAYS);
  end

  assign w_touch_en  = w_fill_done | ((r_state == S_IDLE) & w_req & w_is_hit);
  assign w_touch_way = w_fill_done ? r_victim_way : w_hit_way;
  assign w_touch_set = w_fill_done ? r_miss_set : i_set_idx;

  // Every node on the accessed way's path is set to point away from it.
  always_comb begin
    int unsigned node;
    logic        dir;
    node       = 1;
    w_plru_upd = r_plru[w_touch_set];
    for (int l = 0; l < int'(WAY_BITS); l++) begin
      dir                = w_touch_way[int'(WAY_BITS) - 1 - l];
      w_plru_upd[node-1] = ~dir;
      node               = 2 * node + 32'(dir);
    end
  end

  // Per-set tree state, cleared on reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int s = 0; s < int'(NUM_SETS); s++) r_plru[s] <= '0;
    end else if (w_touch_en) begin
      r_plru[w_touch_set] <= w_plru_upd;
    end
  end

  assign w_policy_pick = w_plru_pick;
`else
  logic [WAY_BITS-1:0] r_rr [NUM_SETS];

  // Per-set round-robin counter; wraps naturally since WAYS is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int s = 0; s < int'(NUM_SETS); s++) r_rr[s] <= '0;
    end else if (w_fill_done) begin
      r_rr[r_miss_set] <= r_rr[r_miss_set] + WAY_BITS'(1);
    end
  end

  assign w_policy_pick = r_rr[i_set_idx];
`endif

  // State, latched victim and the set being refilled.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_victim_way <= '0;
      r_miss_set   <= '0;
    end else begin
      r_state      <= w_state_next;
      r_victim_way <= w_victim_next;
      if (w_latch_set) r_miss_set <= i_set_idx;
    end
  end

  // Next-state and outputs; hit-path and fill-completion writes are combinational.
  always_comb begin
    w_state_next    = r_state;
    w_victim_next   = r_victim_way;
    w_latch_set     = 1'b0;
    w_fill_done     = 1'b0;
    o_mem_resp      = 1'b0;
    o_pmem_read     = 1'b0;
    o_pmem_write    = 1'b0;
    o_data_write    = '0;
    o_tag_write     = '0;
    o_valid_write   = '0;
    o_dirty_write   = '0;
    o_dirty_in      = 1'b0;
    o_datainmux_sel = 1'b0;
    o_addrmux_sel   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (w_is_hit) begin
            o_mem_resp = 1'b1;
            // A simultaneous read and write is handled as a write.
            if (i_mem_write) begin
              o_datainmux_sel = 1'b1;
              o_data_write    = i_hit;
              o_dirty_write   = i_hit;
              o_dirty_in      = 1'b1;
            end
          end else begin
            w_victim_next = w_victim;
            w_latch_set   = 1'b1;
            w_state_next  = w_victim_dirty ? S_EVICT : S_FILL;
          end
        end
      end
      S_EVICT: begin
        o_pmem_write  = 1'b1;
        o_addrmux_sel = 1'b1;
        if (i_pmem_resp) w_state_next = S_FILL;
      end
      S_FILL: begin
        o_pmem_read = 1'b1;
        if (i_pmem_resp) begin
          o_data_write  = w_victim_oh;
          o_tag_write   = w_victim_oh;
          o_valid_write = w_victim_oh;
          o_dirty_write = w_victim_oh;
          w_fill_done   = 1'b1;
          w_state_next  = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

endmodule

// File: doc/cache_control_nway.md
# cache_control_nway

Parametrised N-way set-associative write-back cache controller, next generation of the 2-way controller. It sits between the CPU memory port and physical memory and drives the per-way tag, valid, dirty and data arrays of the cache datapath. Unlike the 2-way block, it owns per-set replacement state internally, prefers invalid ways when choosing a victim, and leaves arrays untouched on read hits.

## Interface
- WAYS, 4, associativity; power of 2, ≥2
- SET_BITS, 3, set-index width; NUM_SETS = 2**SET_BITS
- WAY_BITS, $clog2(WAYS), derived; not overridden
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- mem_read / mem_write  in  1 each  CPU request, held until mem_resp
- set_idx  in  SET_BITS  set of current CPU address
- hit  in  WAYS  per-way tag match AND valid (at most one bit set)
- valid / dirty  in  WAYS each  per-way status of indexed set
- pmem_resp  in  1  physical-memory completion
- mem_resp  out  1  CPU request complete
- pmem_read / pmem_write  out  1 each  physical-memory request, level until pmem_resp
- data_write, tag_write, valid_write, dirty_write  out  WAYS each  one-hot array write enables
- dirty_in  out  1  value written to dirty array
- datainmux_sel  out  1  0 = line from pmem, 1 = CPU-merged line
- addrmux_sel  out  1  0 = CPU address, 1 = victim tag/set (writeback)
- victim_way  out  WAY_BITS  latched victim index; drives writeback tag/data muxes

## Operation
- States: S_IDLE, S_EVICT, S_FILL.
- S_IDLE, hit with mem_read: mem_resp=1; no array writes; replacement state of set_idx updated toward hit way.
- S_IDLE, hit with mem_write: mem_resp=1, datainmux_sel=1, data_write and dirty_write on hit way, dirty_in=1; replacement updated.
- mem_read and mem_write both high: treated as write.
- S_IDLE miss (request, hit==0): victim = lowest-index invalid way, else replacement policy pick; latched into victim_way. If valid[v]&&dirty[v] → S_EVICT, else → S_FILL.
- S_EVICT: pmem_write=1, addrmux_sel=1; on pmem_resp → S_FILL.
- S_FILL: pmem_read=1, addrmux_sel=0; on pmem_resp assert data_write, tag_write, valid_write, dirty_write on victim way, dirty_in=0, datainmux_sel=0, update replacement state (victim as accessed); → S_IDLE. Request then re-evaluates as hit.
- No request in S_IDLE: stay, all outputs 0. pmem_resp outside EVICT/FILL ignored.
- CPU request deasserted mid-miss: current EVICT/FILL still completes; no mem_resp issued.

## Timing
- Reset: state S_IDLE, all replacement state 0, victim_way 0; every output 0 during and the cycle after reset (no request assumed). Reset mid-miss aborts immediately; pmem_* drop next cycle.
- Hit latency: mem_resp combinational in the request cycle (0 wait states).
- Clean miss: 1 (IDLE) + fill cycles + 1 hit cycle. Dirty miss adds eviction cycles.
- All outputs Moore on state except hit-path outputs and fill-completion writes, which are combinational on hit/pmem_resp.
- Replacement-state and victim_way updates take effect next edge.

## Configuration
- CACHE_CTRL_PLRU_EN defined: tree pseudo-LRU, WAYS-1 bits per set; each access sets every node on its path to point away from the accessed way; victim found by following node bits (0 = left/lower).
- Undefined: per-set WAY_BITS round-robin counter; victim = counter value; counter increments (wrapping WAYS-1 → 0) only on fill completion; hits do not change it.

## Test plan
- Reset, WAYS=4, all invalid; read set 2 → victim_way=0, S_FILL, pmem_read until pmem_resp, valid_write=4'b0001, then mem_resp.
- Fill set 0 all 4 ways; write hit way 2 → mem_resp same cycle, data_write=dirty_write=4'b0100, dirty_in=1.
- PLRU_EN: access ways 0,1,2,3 of set 1 in order, miss → victim 0; then hit way 0, miss → victim 2.
- No PLRU_EN: five fills to full set 3 → victims 0,1,2,3,0 after invalid ways exhausted (counter wrap).
- Miss with victim dirty: pmem_write asserted with addrmux_sel=1 until pmem_resp, then pmem_read; no mem_resp before fill completes.
- rst pulsed during S_EVICT → pmem_write=0 next cycle, state S_IDLE, replacement state cleared.
